zap_walk_arbiter: RTL and testbench
===================================

ZAP_WALK_ARBITER -- requirements
Module: zap_walk_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 32'd256: cycles a beat may wait for ack/err before abort; legal range 2..65535.
REQ-002 SHALL have port i_clk, input, 1: single clock; all state updates on rising edge.
REQ-003 SHALL have port i_reset_n, input, 1: asynchronous, active-low reset.
REQ-004 SHALL have I-side walker ports i_i_cyc, i_i_stb, i_i_wen (inputs, 1 each), i_i_adr (input, 32) and i_i_sel (input, 4): next-cycle Wishbone request from the instruction TLB walker.
REQ-005 SHALL have D-side walker ports i_d_cyc, i_d_stb, i_d_wen (inputs, 1 each), i_d_adr (input, 32) and i_d_sel (input, 4): same request set from the data TLB walker.
REQ-006 SHALL have o_i_ack, o_i_err, o_d_ack, o_d_err (outputs, 1 each): per-walker completion strobes.
REQ-007 SHALL have o_i_dat and o_d_dat (outputs, 32 each): read data.
REQ-008 SHALL have o_wb_cyc, o_wb_stb, o_wb_wen (outputs, 1 each), o_wb_adr (output, 32) and o_wb_sel (output, 4): registered master bus.
REQ-009 SHALL have i_wb_dat (input, 32), i_wb_ack (input, 1) and i_wb_err (input, 1): slave response.
REQ-010 SHALL have o_grant (output, 2): bit0 = I owns the bus, bit1 = D owns it; one-hot or zero.

Function
REQ-011 SHALL implement states IDLE, OWN_I, OWN_D and DRAIN; o_grant = {state==OWN_D, state==OWN_I}.
REQ-012 SHALL treat a walker as requesting when its cyc and stb are both 1.
REQ-013 In IDLE with only one walker requesting, SHALL move to that walker's OWN state and register its cyc/stb/wen/adr/sel onto o_wb_* at the same edge: 1-cycle request-to-bus latency.
REQ-014 In IDLE with both walkers requesting, SHALL grant the walker not recorded in the last-served pointer, then set the pointer to the granted walker.
REQ-015 In IDLE with no request, SHALL drive o_wb_cyc = o_wb_stb = 0 and keep o_wb_adr/sel/wen at their last values.
REQ-016 In OWN_x, SHALL register walker x's request signals onto o_wb_* every cycle, with no added bubble between beats of one cycle.
REQ-017 In OWN_x, when i_x_cyc = 0, SHALL go to IDLE with o_wb_cyc = o_wb_stb = 0 at the next edge; the other walker can be granted no earlier than the following edge (cyc low at least 1 cycle between owners).
REQ-018 SHALL drive o_x_ack = i_wb_ack & o_wb_stb & (state==OWN_x), combinationally.
REQ-019 SHALL drive o_x_err = (i_wb_err & o_wb_stb & (state==OWN_x)) | timeout_x, combinationally.
REQ-020 SHALL route o_i_dat = o_d_dat = i_wb_dat unconditionally.
REQ-021 SHALL ignore ack/err arriving in IDLE or DRAIN; nothing is forwarded.
REQ-022 Timeout counter, width $clog2(TIMEOUT)+1: cleared when not in OWN_x, when o_wb_stb = 0, or when ack/err is seen; incremented otherwise.
REQ-023 timeout_x SHALL assert for exactly one cycle when the counter equals TIMEOUT-1 in OWN_x and neither i_wb_ack nor i_wb_err is asserted.
REQ-024 On timeout, next state SHALL be DRAIN with o_wb_cyc = o_wb_stb = 0; the owner is retained internally.
REQ-025 If ack and timeout coincide, ack SHALL win: no err, no DRAIN.
REQ-026 DRAIN SHALL keep bus outputs idle and both grant bits 0, and move to IDLE once the retained owner's i_x_cyc = 0.
REQ-027 A slave i_wb_err SHALL NOT cause DRAIN; ownership follows REQ-017.
REQ-028 A walker asserting cyc with stb = 0 in IDLE SHALL NOT be granted.

Reset
REQ-029 While i_reset_n = 0, SHALL immediately force: state IDLE; last-served pointer D, so I wins the first tie; counter 0; o_wb_cyc, o_wb_stb, o_wb_wen = 0; o_wb_adr = 0; o_wb_sel = 0; o_grant = 0.
REQ-030 Combinational ack/err outputs SHALL be 0 during reset as a consequence of state IDLE.
REQ-031 Reset asserted mid-transaction SHALL abandon the beat with no err issued; after deassert, the first grant occurs 1 cycle after a request is sampled.

Verification
REQ-032 Single I read: i_i_cyc/stb = 1, adr 0x0000_4000 at cycle 0 -> o_wb_stb = 1 and adr 0x0000_4000 at cycle 1, o_grant = 01; i_wb_ack with dat 0xDEAD_BEEF at cycle 3 -> o_i_ack = 1 and o_i_dat = 0xDEAD_BEEF at cycle 3, o_d_ack = 0.
REQ-033 Tie after reset: both request at cycle 0 -> o_grant = 01 at cycle 1; I drops cyc at cycle 4 -> o_wb_cyc = 0 at cycle 5 and o_grant = 10 at cycle 6; the next tie grants I.
REQ-034 Two-level walk: I holds cyc, beat 1 acked at cycle 3 with the next address 0x0000_8004 presented the same cycle -> o_wb_adr = 0x0000_8004 and stb = 1 at cycle 4, grant unchanged.
REQ-035 Timeout with TIMEOUT = 4: D beat with no ack -> o_d_err pulses on the 4th stalled cycle, bus idle on the next cycle, state DRAIN; D drops cyc -> IDLE the next cycle; ack at the 4th cycle instead -> o_d_ack = 1, no err.
REQ-036 Reset mid-beat: i_reset_n low during OWN_D -> o_wb_cyc = 0 and o_grant = 00 immediately, o_d_err = 0; stray i_wb_ack after reset -> no ack forwarded.

Source files
------------

// File: rtl/zap_walk_arbiter.sv
// zap_walk_arbiter: arbitrates I/D TLB walkers onto one registered Wishbone master with round-robin ties and beat timeout
module zap_walk_arbiter #(
  parameter int unsigned TIMEOUT = 32'd256
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_i_cyc,
  input  logic        i_i_stb,
  input  logic        i_i_wen,
  input  logic [31:0] i_i_adr,
  input  logic [3:0]  i_i_sel,
  input  logic        i_d_cyc,
  input  logic        i_d_stb,
  input  logic        i_d_wen,
  input  logic [31:0] i_d_adr,
  input  logic [3:0]  i_d_sel,
  output logic        o_i_ack,
  output logic        o_i_err,
  output logic        o_d_ack,
  output logic        o_d_err,
  output logic [31:0] o_i_dat,
  output logic [31:0] o_d_dat,
  output logic        o_wb_cyc,
  output logic        o_wb_stb,
  output logic        o_wb_wen,
  output logic [31:0] o_wb_adr,
  output logic [3:0]  o_wb_sel,
  input  logic [31:0] i_wb_dat,
  input  logic        i_wb_ack,
  input  logic        i_wb_err,
  output logic [1:0]  o_grant
);
  localparam int CW = $clog2(TIMEOUT) + 1;
  typedef enum logic [1:0] {IDLE, OWN_I, OWN_D, DRAIN} state_t;
  state_t         state;
  logic           last_d;
  logic [CW-1:0]  cnt;
  logic           req_i, req_d, own_i, own_d, own, tmo, pick_i, src_d;
  logic           x_cyc, x_stb, x_wen;
  logic [31:0]    x_adr;
  logic [3:0]     x_sel;
  assign req_i  = i_i_cyc & i_i_stb;
  assign req_d  = i_d_cyc & i_d_stb;
  assign own_i  = state == OWN_I;
  assign own_d  = state == OWN_D;
  assign own    = own_i | own_d;
  assign tmo    = own & o_wb_stb & (cnt == CW'(TIMEOUT - 1)) & ~i_wb_ack & ~i_wb_err;
  assign o_grant = {own_d, own_i};
  assign o_i_ack = i_wb_ack & o_wb_stb & own_i;
  assign o_d_ack = i_wb_ack & o_wb_stb & own_d;
  assign o_i_err = own_i & ((i_wb_err & o_wb_stb) | tmo);
  assign o_d_err = own_d & ((i_wb_err & o_wb_stb) | tmo);
  assign o_i_dat = i_wb_dat;
  assign o_d_dat = i_wb_dat;
  // last_d always tracks the current (or drained) owner, so it doubles as the retained owner
  assign pick_i = req_i & (~req_d | last_d);
  assign src_d  = (state == IDLE) ? ~pick_i : last_d;
  assign x_cyc  = src_d ? i_d_cyc : i_i_cyc;
  assign x_stb  = src_d ? i_d_stb : i_i_stb;
  assign x_wen  = src_d ? i_d_wen : i_i_wen;
  assign x_adr  = src_d ? i_d_adr : i_i_adr;
  assign x_sel  = src_d ? i_d_sel : i_i_sel;
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state    <= IDLE;
      last_d   <= 1'b1;
      cnt      <= '0;
      o_wb_cyc <= 1'b0;
      o_wb_stb <= 1'b0;
      o_wb_wen <= 1'b0;
      o_wb_adr <= '0;
      o_wb_sel <= '0;
    end else begin
      cnt <= (!own || !o_wb_stb || i_wb_ack || i_wb_err || tmo) ? '0 : cnt + 1'b1;
      case (state)
        IDLE: if (req_i || req_d) begin
          state    <= src_d ? OWN_D : OWN_I;
          last_d   <= src_d;
          o_wb_cyc <= 1'b1;
          o_wb_stb <= 1'b1;
          o_wb_wen <= x_wen;
          o_wb_adr <= x_adr;
          o_wb_sel <= x_sel;
        end
        OWN_I, OWN_D: if (tmo || !x_cyc) begin
          state    <= tmo ? DRAIN : IDLE;
          o_wb_cyc <= 1'b0;
          o_wb_stb <= 1'b0;
        end else begin
          o_wb_cyc <= 1'b1;
          o_wb_stb <= x_stb;
          o_wb_wen <= x_wen;
          o_wb_adr <= x_adr;
          o_wb_sel <= x_sel;
        end
        DRAIN: if (!x_cyc) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_zap_walk_arbiter.sv
// tb_zap_walk_arbiter: directed vector table, async reset sequence and randomized run against a reference model
module tb_zap_walk_arbiter;
  localparam int TO = 4;
  logic        clk = 1'b0, rst_n;
  logic        i_cyc, i_stb, i_wen, d_cyc, d_stb, d_wen;
  logic [31:0] i_adr, d_adr, wb_dat;
  logic [3:0]  i_sel, d_sel;
  logic        wb_ack, wb_err;
  logic        o_i_ack, o_i_err, o_d_ack, o_d_err;
  logic [31:0] o_i_dat, o_d_dat, o_wb_adr;
  logic        o_wb_cyc, o_wb_stb, o_wb_wen;
  logic [3:0]  o_wb_sel;
  logic [1:0]  o_grant;
  int checks = 0, errors = 0;

  zap_walk_arbiter #(.TIMEOUT(TO)) dut (
    .i_clk(clk), .i_reset_n(rst_n),
    .i_i_cyc(i_cyc), .i_i_stb(i_stb), .i_i_wen(i_wen), .i_i_adr(i_adr), .i_i_sel(i_sel),
    .i_d_cyc(d_cyc), .i_d_stb(d_stb), .i_d_wen(d_wen), .i_d_adr(d_adr), .i_d_sel(d_sel),
    .o_i_ack(o_i_ack), .o_i_err(o_i_err), .o_d_ack(o_d_ack), .o_d_err(o_d_err),
    .o_i_dat(o_i_dat), .o_d_dat(o_d_dat),
    .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb), .o_wb_wen(o_wb_wen), .o_wb_adr(o_wb_adr), .o_wb_sel(o_wb_sel),
    .i_wb_dat(wb_dat), .i_wb_ack(wb_ack), .i_wb_err(wb_err), .o_grant(o_grant)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic ic, is; logic [31:0] ia;
    logic dc, ds; logic [31:0] da;
    logic ack, err;
    logic [1:0] g; logic cyc, stb; logic [31:0] adr;
    logic iack, dack, ierr, derr;
  } vec_t;
  vec_t tbl[$];

  function automatic vec_t v(logic ic, logic is, logic [31:0] ia, logic dc, logic ds, logic [31:0] da,
                             logic ack, logic err, logic [1:0] g, logic cyc, logic stb, logic [31:0] adr,
                             logic iack, logic dack, logic ierr, logic derr);
    vec_t r;
    r = '{ic, is, ia, dc, ds, da, ack, err, g, cyc, stb, adr, iack, dack, ierr, derr};
    return r;
  endfunction

  // reference model: owner 0 none / 1 I / 2 D, drain flag, stall cycles of the current beat
  int          m_own, m_last, m_wait;
  bit          m_drain;
  logic        m_cyc, m_stb, m_wen;
  logic [31:0] m_adr;
  logic [3:0]  m_sel;

  task automatic model_reset();
    m_own = 0; m_last = 2; m_wait = 0; m_drain = 0;
    m_cyc = 0; m_stb = 0; m_wen = 0; m_adr = 0; m_sel = 0;
  endtask

  function automatic bit timed_out();
    return m_own != 0 && !m_drain && m_stb && m_wait == TO - 1 && !wb_ack && !wb_err;
  endfunction

  task automatic load(input int w);
    m_cyc = 1'b1;
    m_stb = (w == 1) ? i_stb : d_stb;
    m_wen = (w == 1) ? i_wen : d_wen;
    m_adr = (w == 1) ? i_adr : d_adr;
    m_sel = (w == 1) ? i_sel : d_sel;
  endtask

  task automatic model_check();
    bit act, slave, to;
    act = m_own != 0 && !m_drain;
    slave = act && m_stb;
    to = timed_out();
    chk("grant", o_grant, act ? m_own : 0);
    chk("wb_cyc", o_wb_cyc, m_cyc);
    chk("wb_stb", o_wb_stb, m_stb);
    chk("wb_wen", o_wb_wen, m_wen);
    chk("wb_adr", o_wb_adr, m_adr);
    chk("wb_sel", o_wb_sel, m_sel);
    chk("i_ack", o_i_ack, slave && wb_ack && m_own == 1);
    chk("d_ack", o_d_ack, slave && wb_ack && m_own == 2);
    chk("i_err", o_i_err, m_own == 1 && ((slave && wb_err) || to));
    chk("d_err", o_d_err, m_own == 2 && ((slave && wb_err) || to));
    chk("i_dat", o_i_dat, wb_dat);
    chk("d_dat", o_d_dat, wb_dat);
  endtask

  task automatic model_step();
    bit to, ri, rd, oc;
    to = timed_out();
    m_wait = (m_own != 0 && !m_drain && m_stb && !wb_ack && !wb_err && !to) ? m_wait + 1 : 0;
    ri = i_cyc && i_stb;
    rd = d_cyc && d_stb;
    oc = (m_own == 1) ? i_cyc : d_cyc;
    if (m_own == 0) begin
      if (ri || rd) begin
        m_own = (ri && rd) ? 3 - m_last : (ri ? 1 : 2);
        m_last = m_own;
        load(m_own);
      end
    end else if (m_drain) begin
      if (!oc) begin m_own = 0; m_drain = 0; end
    end else if (to) begin
      m_drain = 1; m_cyc = 0; m_stb = 0;
    end else if (!oc) begin
      m_own = 0; m_cyc = 0; m_stb = 0;
    end else load(m_own);
  endtask

  initial begin
    rst_n = 0;
    {i_cyc, i_stb, i_wen, d_cyc, d_stb, d_wen, wb_ack, wb_err} = '0;
    i_adr = 0; d_adr = 0; i_sel = 4'hF; d_sel = 4'hF; wb_dat = 32'hDEAD_BEEF;
    repeat (2) @(posedge clk);
    #1;
    chk("rst grant", o_grant, 0);
    chk("rst cyc", o_wb_cyc, 0);
    chk("rst stb", o_wb_stb, 0);
    chk("rst wen", o_wb_wen, 0);
    chk("rst adr", o_wb_adr, 0);
    chk("rst sel", o_wb_sel, 0);
    rst_n = 1;
    // tie after reset, hand-over with one idle cycle, alternating ties
    tbl.push_back(v(1,1,'h100, 1,1,'h200, 0,0, 0,0,0,'h0,   0,0,0,0));
    tbl.push_back(v(1,1,'h100, 1,1,'h200, 0,0, 1,1,1,'h100, 0,0,0,0));
    tbl.push_back(v(1,1,'h100, 1,1,'h200, 0,0, 1,1,1,'h100, 0,0,0,0));
    tbl.push_back(v(1,1,'h100, 1,1,'h200, 1,0, 1,1,1,'h100, 1,0,0,0));
    tbl.push_back(v(0,0,'h100, 1,1,'h200, 0,0, 1,1,1,'h100, 0,0,0,0));
    tbl.push_back(v(0,0,'h100, 1,1,'h200, 0,0, 0,0,0,'h100, 0,0,0,0));
    tbl.push_back(v(0,0,'h100, 1,1,'h200, 1,0, 2,1,1,'h200, 0,1,0,0));
    tbl.push_back(v(0,0,'h100, 0,0,'h200, 0,0, 2,1,1,'h200, 0,0,0,0));
    tbl.push_back(v(1,1,'h100, 1,1,'h200, 0,0, 0,0,0,'h200, 0,0,0,0));
    tbl.push_back(v(1,1,'h100, 1,1,'h200, 1,0, 1,1,1,'h100, 1,0,0,0));
    tbl.push_back(v(0,0,'h100, 0,0,'h200, 0,0, 1,1,1,'h100, 0,0,0,0));
    tbl.push_back(v(0,0,'h100, 0,0,'h200, 0,0, 0,0,0,'h100, 0,0,0,0));
    // single I read
    tbl.push_back(v(1,1,'h4000, 0,0,0, 0,0, 0,0,0,'h100,  0,0,0,0));
    tbl.push_back(v(1,1,'h4000, 0,0,0, 0,0, 1,1,1,'h4000, 0,0,0,0));
    tbl.push_back(v(1,1,'h4000, 0,0,0, 0,0, 1,1,1,'h4000, 0,0,0,0));
    tbl.push_back(v(1,1,'h4000, 0,0,0, 1,0, 1,1,1,'h4000, 1,0,0,0));
    tbl.push_back(v(0,0,'h4000, 0,0,0, 0,0, 1,1,1,'h4000, 0,0,0,0));
    tbl.push_back(v(0,0,'h4000, 0,0,0, 0,0, 0,0,0,'h4000, 0,0,0,0));
    // two-level walk, back-to-back beats
    tbl.push_back(v(1,1,'h8000, 0,0,0, 0,0, 0,0,0,'h4000, 0,0,0,0));
    tbl.push_back(v(1,1,'h8000, 0,0,0, 0,0, 1,1,1,'h8000, 0,0,0,0));
    tbl.push_back(v(1,1,'h8000, 0,0,0, 0,0, 1,1,1,'h8000, 0,0,0,0));
    tbl.push_back(v(1,1,'h8004, 0,0,0, 1,0, 1,1,1,'h8000, 1,0,0,0));
    tbl.push_back(v(1,1,'h8004, 0,0,0, 0,0, 1,1,1,'h8004, 0,0,0,0));
    tbl.push_back(v(1,1,'h8004, 0,0,0, 1,0, 1,1,1,'h8004, 1,0,0,0));
    tbl.push_back(v(0,0,'h8004, 0,0,0, 0,0, 1,1,1,'h8004, 0,0,0,0));
    tbl.push_back(v(0,0,'h8004, 0,0,0, 0,0, 0,0,0,'h8004, 0,0,0,0));
    // cyc without stb is not granted; stray ack/err in IDLE ignored
    tbl.push_back(v(1,0,'h9000, 0,0,0, 0,0, 0,0,0,'h8004, 0,0,0,0));
    tbl.push_back(v(1,0,'h9000, 0,0,0, 0,0, 0,0,0,'h8004, 0,0,0,0));
    tbl.push_back(v(0,0,'h9000, 0,0,0, 1,1, 0,0,0,'h8004, 0,0,0,0));
    // D timeout, drain, then ack coinciding with timeout, then slave err
    tbl.push_back(v(0,0,0, 1,1,'h300, 0,0, 0,0,0,'h8004, 0,0,0,0));
    tbl.push_back(v(0,0,0, 1,1,'h300, 0,0, 2,1,1,'h300,  0,0,0,0));
    tbl.push_back(v(0,0,0, 1,1,'h300, 0,0, 2,1,1,'h300,  0,0,0,0));
    tbl.push_back(v(0,0,0, 1,1,'h300, 0,0, 2,1,1,'h300,  0,0,0,0));
    tbl.push_back(v(0,0,0, 1,1,'h300, 0,0, 2,1,1,'h300,  0,0,0,1));
    tbl.push_back(v(1,1,'h100, 1,1,'h300, 1,1, 0,0,0,'h300, 0,0,0,0));
    tbl.push_back(v(1,1,'h100, 0,0,'h300, 0,0, 0,0,0,'h300, 0,0,0,0));
    tbl.push_back(v(1,1,'h100, 0,0,0, 0,0, 0,0,0,'h300, 0,0,0,0));
    tbl.push_back(v(1,1,'h100, 0,0,0, 0,0, 1,1,1,'h100, 0,0,0,0));
    tbl.push_back(v(1,1,'h100, 0,0,0, 0,0, 1,1,1,'h100, 0,0,0,0));
    tbl.push_back(v(1,1,'h100, 0,0,0, 0,0, 1,1,1,'h100, 0,0,0,0));
    tbl.push_back(v(1,1,'h100, 0,0,0, 1,0, 1,1,1,'h100, 1,0,0,0));
    tbl.push_back(v(1,1,'h100, 0,0,0, 0,1, 1,1,1,'h100, 0,0,1,0));
    tbl.push_back(v(0,0,'h100, 0,0,0, 0,0, 1,1,1,'h100, 0,0,0,0));
    tbl.push_back(v(0,0,0,     0,0,0, 0,0, 0,0,0,'h100, 0,0,0,0));
    for (int n = 0; n < tbl.size(); n++) begin
      {i_cyc, i_stb, i_adr} = {tbl[n].ic, tbl[n].is, tbl[n].ia};
      {d_cyc, d_stb, d_adr} = {tbl[n].dc, tbl[n].ds, tbl[n].da};
      {wb_ack, wb_err} = {tbl[n].ack, tbl[n].err};
      @(negedge clk);
      chk($sformatf("row%0d grant", n), o_grant, tbl[n].g);
      chk($sformatf("row%0d cyc", n), o_wb_cyc, tbl[n].cyc);
      chk($sformatf("row%0d stb", n), o_wb_stb, tbl[n].stb);
      chk($sformatf("row%0d adr", n), o_wb_adr, tbl[n].adr);
      chk($sformatf("row%0d i_ack", n), o_i_ack, tbl[n].iack);
      chk($sformatf("row%0d d_ack", n), o_d_ack, tbl[n].dack);
      chk($sformatf("row%0d i_err", n), o_i_err, tbl[n].ierr);
      chk($sformatf("row%0d d_err", n), o_d_err, tbl[n].derr);
      if (tbl[n].ack) chk($sformatf("row%0d i_dat", n), o_i_dat, 32'hDEAD_BEEF);
      @(posedge clk);
      #1;
    end
    // asynchronous reset in the middle of a D beat
    d_cyc = 1; d_stb = 1; d_adr = 'h500;
    repeat (2) @(posedge clk);
    #3;
    rst_n = 0; wb_ack = 1;
    #1;
    chk("mid rst cyc", o_wb_cyc, 0);
    chk("mid rst grant", o_grant, 0);
    chk("mid rst adr", o_wb_adr, 0);
    chk("mid rst d_ack", o_d_ack, 0);
    chk("mid rst d_err", o_d_err, 0);
    @(posedge clk);
    #1;
    rst_n = 1;
    @(negedge clk);
    chk("post rst grant", o_grant, 0);
    chk("post rst stray ack", o_d_ack, 0);
    @(posedge clk);
    #1;
    wb_ack = 0;
    @(negedge clk);
    chk("post rst first grant", o_grant, 2);
    chk("post rst adr", o_wb_adr, 'h500);
    // randomized run against the reference model
    rst_n = 0;
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1;
    i_cyc = 0; d_cyc = 0;
    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(7) == 0) i_cyc = ~i_cyc;
      if ($urandom_range(7) == 0) d_cyc = ~d_cyc;
      i_stb = $urandom_range(3) != 0;
      d_stb = $urandom_range(3) != 0;
      i_wen = $urandom_range(1);
      d_wen = $urandom_range(1);
      i_adr = $urandom;
      d_adr = $urandom;
      i_sel = 4'($urandom);
      d_sel = 4'($urandom);
      wb_ack = $urandom_range(4) == 0;
      wb_err = $urandom_range(15) == 0;
      wb_dat = $urandom;
      @(negedge clk);
      model_check();
      @(posedge clk);
      model_step();
      #1;
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
